// File: rtl/display_scheduler.sv
// display_scheduler: round-robin time-multiplexer of NUM_SRC 16-bit
// sources onto one seven_seg driver, with dwell, blank gap, hold, next.
// Ports: clk, rst (sync, active-high); src_data/src_valid (per source);
//   hold (freeze dwell), next (force advance); display_value, sel,
//   blank, switch_pulse (all registered).
module display_scheduler #(
  parameter int NUM_SRC      = 4,
  parameter int DWELL_CYCLES = 200_000_000,
  parameter int BLANK_CYCLES = 10_000_000,
  parameter int SEL_W        = $clog2(NUM_SRC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [16*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]    src_valid,
  input  logic                  hold,
  input  logic                  next,
  output logic [15:0]           display_value,
  output logic [SEL_W-1:0]      sel,
  output logic                  blank,
  output logic                  switch_pulse
);

  localparam int MAX_CYC =
    (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int TW = $clog2(MAX_CYC);
  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_SRC - 1);

  typedef enum logic {
    S_BLANK,
    S_SHOW
  } state_t;

  state_t           state, state_nx;
  logic [SEL_W-1:0] start, start_nx, sel_nx, sel_inc;
  logic [TW-1:0]    timer, timer_nx;
  logic [15:0]      value_nx, cur_data, found_data;
  logic             blank_nx, pulse_nx;
  logic             found, advance;
  logic [SEL_W-1:0] found_idx;

  // Search from start, wrapping; walking offsets downward makes the
  // smallest offset (closest to start) the final winner.
  always_comb begin
    int j;
    j         = 0;
    found     = 1'b0;
    found_idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      j = int'(start) + k;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (src_valid[j]) begin
        found     = 1'b1;
        found_idx = SEL_W'(j);
      end
    end
  end

  always_comb begin
    cur_data   = '0;
    found_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (SEL_W'(i) == sel)       cur_data   = src_data[16*i +: 16];
      if (SEL_W'(i) == found_idx) found_data = src_data[16*i +: 16];
    end
  end

  assign sel_inc = (sel == SEL_LAST) ? '0 : sel + SEL_W'(1);

  assign advance = next || !src_valid[sel] ||
                   (!hold && timer == DWELL_LAST);

  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    start_nx = start;
    timer_nx = timer;
    value_nx = display_value;
    blank_nx = blank;
    pulse_nx = 1'b0;
    unique case (state)
      S_BLANK: begin
        if (timer == BLANK_LAST) begin
          timer_nx = '0;
          if (found) begin
            state_nx = S_SHOW;
            sel_nx   = found_idx;
            value_nx = found_data;
            blank_nx = 1'b0;
            pulse_nx = 1'b1;
          end
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      S_SHOW: begin
        value_nx = cur_data;
        if (advance) begin
          state_nx = S_BLANK;
          blank_nx = 1'b1;
          start_nx = sel_inc;
          timer_nx = '0;
        end else if (!hold) begin
          timer_nx = timer + TW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_BLANK;
      sel           <= '0;
      start         <= '0;
      timer         <= '0;
      display_value <= '0;
      blank         <= 1'b1;
      switch_pulse  <= 1'b0;
    end else begin
      state         <= state_nx;
      sel           <= sel_nx;
      start         <= start_nx;
      timer         <= timer_nx;
      display_value <= value_nx;
      blank         <= blank_nx;
      switch_pulse  <= pulse_nx;
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed self-checking bench for display_scheduler
// with NUM_SRC=4, DWELL_CYCLES=8, BLANK_CYCLES=2.
module tb_display_scheduler;

  localparam int NUM_SRC = 4;
  localparam int DWELL   = 8;
  localparam int BLANKC  = 2;
  localparam int SEL_W   = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [16*NUM_SRC-1:0] src_data = '0;
  logic [NUM_SRC-1:0]    src_valid = '0;
  logic                  hold = 1'b0;
  logic                  next = 1'b0;
  logic [15:0]           display_value;
  logic [SEL_W-1:0]      sel;
  logic                  blank;
  logic                  switch_pulse;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  display_scheduler #(
    .NUM_SRC(NUM_SRC),
    .DWELL_CYCLES(DWELL),
    .BLANK_CYCLES(BLANKC),
    .SEL_W(SEL_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .src_data(src_data),
    .src_valid(src_valid),
    .hold(hold),
    .next(next),
    .display_value(display_value),
    .sel(sel),
    .blank(blank),
    .switch_pulse(switch_pulse)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic skip(input int n);
    repeat (n) tick();
  endtask

  // Leaves the bench on the first post-reset cycle (blank gap cycle 0).
  task automatic do_reset();
    rst = 1'b1;
    hold = 1'b0;
    next = 1'b0;
    src_data = {16'h4000, 16'h3000, 16'h2000, 16'h1000};
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [15:0] exp_data(input int s);
    return 16'((s + 1) * 16'h1000);
  endfunction

  task automatic test_reset();
    int seq [5] = '{0, 1, 2, 3, 0};
    logic [15:0] ev;
    src_valid = 4'hF;
    do_reset();
    checks++;
    if (blank !== 1'b1 || sel !== 2'd0 || display_value !== 16'h0 ||
        switch_pulse !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got blank=%b sel=%0d value=%h pulse=%b, want 1 0 0000 0",
               blank, sel, display_value, switch_pulse);
    end
    for (int i = 0; i < 5; i++) begin
      for (int b = 0; b < BLANKC; b++) begin
        checks++;
        if (blank !== 1'b1 || switch_pulse !== 1'b0) begin
          failures++;
          $display("FAIL rot_gap src%0d b%0d: got blank=%b pulse=%b, want 1 0",
                   i, b, blank, switch_pulse);
        end
        if (i == 0) begin
          checks++;
          if (display_value !== 16'h0) begin
            failures++;
            $display("FAIL startup_value b%0d: got %h, want 0000", b, display_value);
          end
        end
        tick();
      end
      ev = exp_data(seq[i]);
      for (int c = 0; c < DWELL; c++) begin
        checks++;
        if (blank !== 1'b0 || sel !== 2'(seq[i]) || display_value !== ev ||
            switch_pulse !== 1'(c == 0)) begin
          failures++;
          $display("FAIL rot_show step%0d c%0d: got blank=%b sel=%0d value=%h pulse=%b, want 0 %0d %h %b",
                   i, c, blank, sel, display_value, switch_pulse,
                   seq[i], ev, c == 0);
        end
        tick();
      end
    end
  endtask

  task automatic test_sparse();
    int seq [4] = '{1, 3, 1, 3};
    logic [15:0] ev;
    src_valid = 4'b1010;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < BLANKC; b++) begin
        checks++;
        if (blank !== 1'b1 || switch_pulse !== 1'b0) begin
          failures++;
          $display("FAIL sparse_gap step%0d b%0d: got blank=%b pulse=%b, want 1 0",
                   i, b, blank, switch_pulse);
        end
        tick();
      end
      ev = exp_data(seq[i]);
      for (int c = 0; c < DWELL; c++) begin
        checks++;
        if (blank !== 1'b0 || sel !== 2'(seq[i]) || display_value !== ev ||
            switch_pulse !== 1'(c == 0)) begin
          failures++;
          $display("FAIL sparse_show step%0d c%0d: got blank=%b sel=%0d value=%h pulse=%b, want 0 %0d %h %b",
                   i, c, blank, sel, display_value, switch_pulse,
                   seq[i], ev, c == 0);
        end
        tick();
      end
    end
  endtask

  task automatic test_hold();
    src_valid = 4'hF;
    do_reset();
    skip(15);
    checks++;
    if (sel !== 2'd1 || blank !== 1'b0) begin
      failures++;
      $display("FAIL hold_nav: got sel=%0d blank=%b, want 1 0", sel, blank);
    end
    hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (sel !== 2'd1 || blank !== 1'b0 || switch_pulse !== 1'b0) begin
        failures++;
        $display("FAIL hold_freeze i%0d: got sel=%0d blank=%b pulse=%b, want 1 0 0",
                 i, sel, blank, switch_pulse);
      end
    end
    hold = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (sel !== 2'd1 || blank !== 1'b0) begin
        failures++;
        $display("FAIL hold_release k%0d: got sel=%0d blank=%b, want 1 0",
                 k, sel, blank);
      end
      tick();
    end
    checks++;
    if (blank !== 1'b1) begin
      failures++;
      $display("FAIL hold_end: got blank=%b, want 1", blank);
    end
  endtask

  task automatic test_next();
    src_valid = 4'hF;
    do_reset();
    skip(22);
    checks++;
    if (sel !== 2'd2 || blank !== 1'b0 || switch_pulse !== 1'b1) begin
      failures++;
      $display("FAIL next_nav: got sel=%0d blank=%b pulse=%b, want 2 0 1",
               sel, blank, switch_pulse);
    end
    skip(2);
    hold = 1'b1;
    skip(3);
    checks++;
    if (sel !== 2'd2 || blank !== 1'b0) begin
      failures++;
      $display("FAIL next_held: got sel=%0d blank=%b, want 2 0", sel, blank);
    end
    next = 1'b1;
    tick();
    next = 1'b0;
    checks++;
    if (blank !== 1'b1 || sel !== 2'd2 || switch_pulse !== 1'b0) begin
      failures++;
      $display("FAIL next_advance: got blank=%b sel=%0d pulse=%b, want 1 2 0",
               blank, sel, switch_pulse);
    end
    tick();
    checks++;
    if (blank !== 1'b1) begin
      failures++;
      $display("FAIL next_gap: got blank=%b, want 1", blank);
    end
    next = 1'b1;
    tick();
    next = 1'b0;
    checks++;
    if (sel !== 2'd3 || blank !== 1'b0 || switch_pulse !== 1'b1 ||
        display_value !== 16'h4000) begin
      failures++;
      $display("FAIL next_in_blank: got sel=%0d blank=%b pulse=%b value=%h, want 3 0 1 4000",
               sel, blank, switch_pulse, display_value);
    end
    hold = 1'b0;
    for (int c = 1; c < DWELL; c++) begin
      tick();
      checks++;
      if (sel !== 2'd3 || blank !== 1'b0 || switch_pulse !== 1'b0) begin
        failures++;
        $display("FAIL next_dwell c%0d: got sel=%0d blank=%b pulse=%b, want 3 0 0",
                 c, sel, blank, switch_pulse);
      end
    end
    next = 1'b1;
    tick();
    next = 1'b0;
    checks++;
    if (blank !== 1'b1) begin
      failures++;
      $display("FAIL next_expiry_b0: got blank=%b, want 1", blank);
    end
    tick();
    checks++;
    if (blank !== 1'b1) begin
      failures++;
      $display("FAIL next_expiry_b1: got blank=%b, want 1", blank);
    end
    tick();
    checks++;
    if (sel !== 2'd0 || blank !== 1'b0 || switch_pulse !== 1'b1) begin
      failures++;
      $display("FAIL next_expiry_single: got sel=%0d blank=%b pulse=%b, want 0 0 1",
               sel, blank, switch_pulse);
    end
  endtask

  task automatic test_valid_drop();
    src_valid = 4'hF;
    do_reset();
    skip(5);
    checks++;
    if (sel !== 2'd0 || blank !== 1'b0) begin
      failures++;
      $display("FAIL drop_nav: got sel=%0d blank=%b, want 0 0", sel, blank);
    end
    src_valid = 4'b1110;
    tick();
    checks++;
    if (blank !== 1'b1 || switch_pulse !== 1'b0) begin
      failures++;
      $display("FAIL drop_blank: got blank=%b pulse=%b, want 1 0",
               blank, switch_pulse);
    end
    src_valid = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (blank !== 1'b1 || switch_pulse !== 1'b0 || sel !== 2'd0 ||
          display_value !== 16'h1000) begin
        failures++;
        $display("FAIL none_valid i%0d: got blank=%b pulse=%b sel=%0d value=%h, want 1 0 0 1000",
                 i, blank, switch_pulse, sel, display_value);
      end
    end
    src_valid = 4'b0100;
    tick();
    checks++;
    if (blank !== 1'b1) begin
      failures++;
      $display("FAIL revalid_wait: got blank=%b, want 1", blank);
    end
    tick();
    checks++;
    if (sel !== 2'd2 || blank !== 1'b0 || switch_pulse !== 1'b1 ||
        display_value !== 16'h3000) begin
      failures++;
      $display("FAIL revalid_show: got sel=%0d blank=%b pulse=%b value=%h, want 2 0 1 3000",
               sel, blank, switch_pulse, display_value);
    end
    src_data[47:32] = 16'hBEEF;
    checks++;
    if (display_value !== 16'h3000) begin
      failures++;
      $display("FAIL live_before: got %h, want 3000", display_value);
    end
    tick();
    checks++;
    if (display_value !== 16'hBEEF || blank !== 1'b0 || switch_pulse !== 1'b0) begin
      failures++;
      $display("FAIL live_after: got value=%h blank=%b pulse=%b, want beef 0 0",
               display_value, blank, switch_pulse);
    end
  endtask

  task automatic test_reset_midshow();
    src_valid = 4'hF;
    do_reset();
    skip(37);
    checks++;
    if (sel !== 2'd3 || blank !== 1'b0) begin
      failures++;
      $display("FAIL rst_nav: got sel=%0d blank=%b, want 3 0", sel, blank);
    end
    rst = 1'b1;
    next = 1'b1;
    hold = 1'b1;
    tick();
    checks++;
    if (blank !== 1'b1 || sel !== 2'd0 || display_value !== 16'h0 ||
        switch_pulse !== 1'b0) begin
      failures++;
      $display("FAIL rst_midshow: got blank=%b sel=%0d value=%h pulse=%b, want 1 0 0000 0",
               blank, sel, display_value, switch_pulse);
    end
    rst = 1'b0;
    next = 1'b0;
    hold = 1'b0;
    tick();
    checks++;
    if (blank !== 1'b1 || display_value !== 16'h0) begin
      failures++;
      $display("FAIL rst_restart_gap: got blank=%b value=%h, want 1 0000",
               blank, display_value);
    end
    tick();
    checks++;
    if (sel !== 2'd0 || blank !== 1'b0 || switch_pulse !== 1'b1 ||
        display_value !== 16'h1000) begin
      failures++;
      $display("FAIL rst_restart_show: got sel=%0d blank=%b pulse=%b value=%h, want 0 0 1 1000",
               sel, blank, switch_pulse, display_value);
    end
    skip(DWELL);
    checks++;
    if (blank !== 1'b1) begin
      failures++;
      $display("FAIL rst_restart_dwell: got blank=%b, want 1", blank);
    end
  endtask

  initial begin
    test_reset();
    test_sparse();
    test_hold();
    test_next();
    test_valid_drop();
    test_reset_midshow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
